sdram_host_responder: RTL

- Synthesizable stand-in for the SDRAM controller's host-side interface. It answers the same wr/rd/busy/rd_ready handshake that the 100 MHz side of the cross-clock FIFOs drives.
- Backed by on-chip block RAM, with programmable service latencies and emulated init/refresh busy windows.
- Lets FIFO and dnano front-end bring-up run without external SDRAM. Also serves as a timing-accurate responder in system simulation.

---
 rtl/sdram_host_pkg.sv | 16 +
 rtl/sdram_host_resp_ram.sv | 30 +++
 rtl/sdram_host_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sdram_host_pkg.sv
// Shared definitions for the SDRAM host-side interface: controller state
// encoding and the default host bus widths used by the controller and dnano front-end.
package sdram_host_pkg;

  localparam int HOST_ADDR_W = 24;
  localparam int HOST_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_REFRESH = 3'd4
  } state_e;

endpackage

// File: rtl/sdram_host_resp_ram.sv
// Single-port block RAM behind the responder: synchronous write, registered
// write-first read. The memory array is never reset; only the output register is.
module host_resp_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= we_i ? wdata_i : mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_host_responder.sv
// Block-RAM stand-in for the SDRAM controller host port: answers wr/rd/busy/rd_ready
// with programmable service latencies plus emulated power-up and refresh busy windows.
module sdram_host_responder
  import sdram_host_pkg::*;
#(
  parameter int HADDR_WIDTH    = HOST_ADDR_W,
  parameter int DATA_WIDTH     = HOST_DATA_W,
  parameter int MEM_AW         = 10,
  parameter int INIT_CYCLES    = 20,
  parameter int WR_CYCLES      = 4,
  parameter int RD_CYCLES      = 6,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [HADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_enable,
  input  logic [HADDR_WIDTH-1:0] rd_addr,
  input  logic                   rd_enable,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_ready,
  output logic                   busy,
  output logic                   refresh_late
);

  localparam int CNT_W = 16;
  localparam int RW    = $clog2(REFRESH_PERIOD + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
  logic                  ref_pend_q, ref_pend_d;
  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  busy_q, rd_ready_q, late_q;
  logic                  last, ref_wrap, ref_take, ram_we, ram_re;
  logic                  unused_addr_hi;

  // Upper host address bits are deliberately dropped: addresses alias modulo 2**MEM_AW.
  assign unused_addr_hi = ^{wr_addr[HADDR_WIDTH-1:MEM_AW], rd_addr[HADDR_WIDTH-1:MEM_AW]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ref_take = 1'b0;
    last     = 1'b0;
    case (state_q)
      ST_INIT:    last = (cnt_q == CNT_W'(INIT_CYCLES - 1));
      ST_IDLE: begin
        cnt_d = '0;
        if (ref_pend_q) begin
          state_d  = ST_REFRESH;
          ref_take = 1'b1;
        end else if (wr_enable) begin
          state_d = ST_WRITE;
          addr_d  = wr_addr[MEM_AW-1:0];
          wdata_d = wr_data;
        end else if (rd_enable) begin
          state_d = ST_READ;
          addr_d  = rd_addr[MEM_AW-1:0];
        end
      end
      ST_WRITE:   last = (cnt_q == CNT_W'(WR_CYCLES - 1));
      ST_READ:    last = (cnt_q == CNT_W'(RD_CYCLES - 1));
      ST_REFRESH: last = (cnt_q == CNT_W'(REFRESH_CYCLES - 1));
      default:    state_d = ST_INIT;
    endcase
    if (last) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // A new expiry wins over a same-cycle acceptance so no refresh is ever lost.
  assign ref_wrap   = (state_q != ST_INIT) && (ref_cnt_q == RW'(REFRESH_PERIOD - 1));
  assign ref_cnt_d  = (state_q == ST_INIT || ref_wrap) ? '0 : ref_cnt_q + 1'b1;
  assign ref_pend_d = ref_wrap | (ref_pend_q & ~ref_take);

  assign ram_we = (state_q == ST_WRITE) && (cnt_q == '0);
  assign ram_re = (state_q == ST_READ) && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b1;
      rd_ready_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= (state_d != ST_IDLE);
      rd_ready_q <= ram_re;
      late_q     <= ref_wrap & ref_pend_q;
    end
  end

  host_resp_ram #(.AW(MEM_AW), .DW(DATA_WIDTH)) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rd_data)
  );

  assign busy         = busy_q;
  assign rd_ready     = rd_ready_q;
  assign refresh_late = late_q;

endmodule
